mac_accumulator: RTL and testbench

Sequential multiply-accumulate back end that consumes the 8-bit product `Y` of the 4x4 array multiplier (`MULTIPLIER4`). It sums a fixed number of products per transaction into a saturating accumulator. It hands the result downstream over a valid/ready handshake. This makes the combinational multiplier usable for dot-product style operand streams.

---
 rtl/mac_pkg.sv | 13 +
 rtl/MULTIPLIER4.sv | 10 +
 rtl/sat_adder.sv | 30 +++
 rtl/mac_accumulator.sv | 80 ++++++++
 tb/tb_mac_accumulator.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the multiply-accumulate back end.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W = 8;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/MULTIPLIER4.sv
// 4x4 unsigned array multiplier that produces the products fed to the accumulator.
module MULTIPLIER4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Y
);

  assign Y = {4'b0000, A} * {4'b0000, B};

endmodule

// File: rtl/sat_adder.sv
// Combinational saturating add of an unsigned 8-bit product onto the accumulator.
module sat_adder
  import mac_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // Top bit of the result is the saturation flag, the rest the clamped sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] wide;
    wide = {1'b0, a} + (ACC_W+1)'(p);
    if (wide[ACC_W])
      return {1'b1, {ACC_W{1'b1}}};
    else
      return {1'b0, wide[ACC_W-1:0]};
  endfunction

  logic [ACC_W:0] res;

  assign res = sat_add(acc, prod);
  assign sum = res[ACC_W-1:0];
  assign sat = res[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS products per transaction into a saturating accumulator and
// presents the result over a valid/ready handshake.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [PROD_W-1:0] PROD,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [ACC_W-1:0]  SUM,
  output logic              OVF,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY
);

  state_t             state_p1, state_nxt;
  logic [CNT_W-1:0]   cnt_p1;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   acc_p1;
  logic [ACC_W-1:0]   acc_nxt;
  logic               ovf_p1;
  logic               sat;
  logic               accept;
  logic               last;

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .acc  (acc_p1),
    .prod (PROD),
    .sum  (acc_nxt),
    .sat  (sat)
  );

  assign accept  = IN_VALID && (state_p1 == ACCUM);
  assign cnt_inc = cnt_p1 + CNT_W'(1);
  assign last    = (cnt_inc == CNT_W'(N_TERMS));

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (START) state_nxt = ACCUM;
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: state, term counter, accumulator and sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      acc_p1   <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (state_p1 == IDLE && START) begin
        cnt_p1 <= '0;
        acc_p1 <= '0;
        ovf_p1 <= 1'b0;
      end else if (accept) begin
        cnt_p1 <= cnt_inc;
        acc_p1 <= acc_nxt;
        if (sat) ovf_p1 <= 1'b1;
      end
    end
  end

  assign IN_READY  = (state_p1 == ACCUM);
  assign OUT_VALID = (state_p1 == HOLD);
  assign BUSY      = (state_p1 != IDLE);
  assign SUM       = acc_p1;
  assign OVF       = ovf_p1;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with the 4x4 multiplier supplying products.
module tb_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a, b;
  logic [7:0] prod;

  logic start0, iv0, ordy0, irdy0, ovf0, ovalid0, busy0;
  logic start1, iv1, ordy1, irdy1, ovf1, ovalid1, busy1;
  logic start2, iv2, ordy2, irdy2, ovf2, ovalid2, busy2;
  logic [11:0] sum0;
  logic [7:0]  sum1;
  logic [11:0] sum2;

  int tests = 0;
  int fails = 0;

  MULTIPLIER4 u_mul (.A(a), .B(b), .Y(prod));

  mac_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dut0 (
    .CLK(clk), .RST(rst), .START(start0), .PROD(prod), .IN_VALID(iv0),
    .IN_READY(irdy0), .SUM(sum0), .OVF(ovf0), .OUT_VALID(ovalid0),
    .OUT_READY(ordy0), .BUSY(busy0));

  mac_accumulator #(.N_TERMS(2), .ACC_W(8)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .PROD(prod), .IN_VALID(iv1),
    .IN_READY(irdy1), .SUM(sum1), .OVF(ovf1), .OUT_VALID(ovalid1),
    .OUT_READY(ordy1), .BUSY(busy1));

  mac_accumulator #(.N_TERMS(1), .ACC_W(12)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start2), .PROD(prod), .IN_VALID(iv2),
    .IN_READY(irdy2), .SUM(sum2), .OVF(ovf2), .OUT_VALID(ovalid2),
    .OUT_READY(ordy2), .BUSY(busy2));

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  prod;
    logic [11:0] acc;
  } vec_t;

  vec_t t1[4];
  logic iv_pat[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_m;
    int n_acc;

    t1[0] = '{a: 4'd13, b: 4'd11, prod: 8'd143, acc: 12'd143};
    t1[1] = '{a: 4'd1,  b: 4'd15, prod: 8'd15,  acc: 12'd158};
    t1[2] = '{a: 4'd13, b: 4'd11, prod: 8'd143, acc: 12'd301};
    t1[3] = '{a: 4'd1,  b: 4'd15, prod: 8'd15,  acc: 12'd316};
    iv_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; a = 4'd0; b = 4'd0;
    start0 = 0; iv0 = 0; ordy0 = 0;
    start1 = 0; iv1 = 0; ordy1 = 0;
    start2 = 0; iv2 = 0; ordy2 = 0;
    tick();
    tick();
    check("rst_sum0", sum0, 0);
    check("rst_irdy0", irdy0, 0);
    check("rst_ovalid0", ovalid0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_ovf1", ovf1, 0);
    rst = 1'b0;
    tick();

    // Test 1: four-term dot product
    start0 = 1; tick(); start0 = 0;
    check("t1_irdy_after_start", irdy0, 1);
    check("t1_busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      a = t1[i].a; b = t1[i].b; iv0 = 1;
      #1;
      check($sformatf("t1_prod%0d", i), prod, t1[i].prod);
      tick();
      check($sformatf("t1_acc%0d", i), sum0, t1[i].acc);
      check($sformatf("t1_ovalid%0d", i), ovalid0, (i == 3));
    end
    iv0 = 0;
    check("t1_ovf", ovf0, 0);
    check("t1_irdy_hold", irdy0, 0);

    // Test 3: backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_sum%0d", i), sum0, 316);
      check($sformatf("t3_ovalid%0d", i), ovalid0, 1);
      check($sformatf("t3_irdy%0d", i), irdy0, 0);
      check($sformatf("t3_ovf%0d", i), ovf0, 0);
    end
    ordy0 = 1; tick(); ordy0 = 0;
    check("t3_idle_ovalid", ovalid0, 0);
    check("t3_idle_busy", busy0, 0);

    // Test 2: saturation at ACC_W=8, then a clean transaction
    start1 = 1; tick(); start1 = 0;
    a = 4'd13; b = 4'd11; iv1 = 1;
    tick(); tick();
    iv1 = 0;
    check("t2_sum_sat", sum1, 255);
    check("t2_ovf", ovf1, 1);
    check("t2_ovalid", ovalid1, 1);
    ordy1 = 1; tick(); ordy1 = 0;
    start1 = 1; tick(); start1 = 0;
    check("t2_ovf_cleared", ovf1, 0);
    check("t2_sum_cleared", sum1, 0);
    a = 4'd1; b = 4'd1; iv1 = 1; tick();
    a = 4'd1; b = 4'd2; tick();
    iv1 = 0;
    check("t2_sum2", sum1, 3);
    check("t2_ovf2", ovf1, 0);
    check("t2_ovalid2", ovalid1, 1);
    ordy1 = 1; tick(); ordy1 = 0;

    // Test 4: bubbles plus a START pulse during ACCUM
    start0 = 1; tick(); start0 = 0;
    a = 4'd3; b = 4'd5;
    acc_m = 0; n_acc = 0;
    for (int j = 0; j < 7; j++) begin
      iv0 = iv_pat[j];
      start0 = (j == 2);
      if (iv_pat[j] && n_acc < 4) begin
        acc_m += 15;
        n_acc++;
      end
      tick();
      check($sformatf("t4_acc%0d", j), sum0, acc_m);
    end
    iv0 = 0; start0 = 0;
    check("t4_sum", sum0, 60);
    check("t4_ovalid", ovalid0, 1);
    ordy0 = 1; tick(); ordy0 = 0;
    check("t4_idle", busy0, 0);

    // Test 5: asynchronous reset mid-transaction
    start0 = 1; tick(); start0 = 0;
    a = 4'd13; b = 4'd11; iv0 = 1; tick();
    a = 4'd1;  b = 4'd15; tick();
    iv0 = 0;
    check("t5_partial", sum0, 158);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_sum", sum0, 0);
    check("t5_rst_irdy", irdy0, 0);
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_ovalid", ovalid0, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_idle_irdy", irdy0, 0);
    start0 = 1; tick(); start0 = 0;
    a = 4'd1; b = 4'd1; iv0 = 1;
    repeat (4) tick();
    iv0 = 0;
    check("t5_sum", sum0, 4);
    check("t5_ovalid", ovalid0, 1);
    ordy0 = 1; tick(); ordy0 = 0;

    // Test 6: single-term transaction, START with OUT_READY ignored
    start2 = 1; tick(); start2 = 0;
    a = 4'd15; b = 4'd15; iv2 = 1; tick(); iv2 = 0;
    check("t6_ovalid", ovalid2, 1);
    check("t6_sum", sum2, 225);
    ordy2 = 1; start2 = 1; tick(); ordy2 = 0; start2 = 0;
    check("t6_idle_busy", busy2, 0);
    check("t6_idle_irdy", irdy2, 0);
    tick();
    check("t6_still_idle", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
